// File: rtl/switch_out_arbiter_pkg.sv
// Shared types and constants for the 4-port switch egress arbiter.
package switch_out_arbiter_pkg;

  localparam int SW_NPORTS = 4;
  localparam int SW_PKT_W  = 16;

  // Packet field slices: {data[7:0], target[3:0], source[3:0]}
  localparam int SRC_LSB  = 0;
  localparam int SRC_W    = 4;
  localparam int TGT_LSB  = 4;
  localparam int TGT_W    = 4;
  localparam int DATA_LSB = 8;
  localparam int DATA_W   = 8;
  localparam int DST_W    = 4;

  // Input-port FSM states and packet types, shared with switch_port.
  typedef enum logic [1:0] {IDLE, ROUTE, ARB_WAIT, TRANSMIT} state_t;
  typedef enum logic [1:0] {ERR, SDP, MDP, BDP} p_type;

  // Egress arbiter FSM.
  typedef enum logic {A_IDLE, A_GRANT} arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TGT_W-1:0]  target;
    logic [SRC_W-1:0]  source;
  } pkt_t;

  // Round-robin pointer advance; the 2-bit width gives the 3 -> 0 wrap.
  function automatic logic [1:0] rr_next(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/switch_out_arbiter_rr_pick.sv
// Combinational 4-request round-robin picker.
// Searches ptr, ptr+1, ... (mod 4) and reports the first set request.
module switch_out_arbiter_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    any    = 1'b0;
    idx    = ptr;
    onehot = '0;
    cand   = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Egress-side arbiter for one output port of the 4-port switch.
// Picks an input port round-robin, issues a one-cycle grant (FIFO pop),
// and captures that port's FIFO head into a registered valid/ready output.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  A_IDLE  | waiting for a routed request and a free output register
//  A_GRANT | one cycle: grant sel if still requesting, load packet
module switch_out_arbiter
  import switch_out_arbiter_pkg::*;
#(
  parameter int OUT_ID = 0,
  parameter int NPORTS = 4,
  parameter int PKT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORTS-1:0]       req_valid,
  input  logic [DST_W*NPORTS-1:0] req_dst,
  input  logic [PKT_W*NPORTS-1:0] pkt_in,
  output logic [NPORTS-1:0]       grant,
  input  logic                    out_ready,
  output logic                    valid_out,
  output logic [SRC_W-1:0]        source_out,
  output logic [TGT_W-1:0]        target_out,
  output logic [DATA_W-1:0]       data_out,
  output logic                    busy,
  output logic [CNT_W-1:0]        pkt_cnt
);

  // Selects this egress port's bit out of each input's pkt_dst nibble.
  localparam logic [DST_W-1:0] DST_MASK = DST_W'(1 << OUT_ID);

  arb_state_t        state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        sel_q, sel_d;
  logic [NPORTS-1:0] sel_oh_q, sel_oh_d;
  logic [NPORTS-1:0] r;
  logic [NPORTS-1:0] pick_onehot;
  logic [1:0]        pick_idx;
  logic              pick_any;
  logic              out_free;
  logic              load;
  pkt_t              head;

  // A request counts only when it is valid and routed to this egress port.
  always_comb begin
    r = '0;
    for (int i = 0; i < NPORTS; i++) begin
      r[i] = req_valid[i] & (|(req_dst[DST_W*i +: DST_W] & DST_MASK));
    end
  end

  assign out_free = !valid_out || out_ready;
  assign head     = pkt_t'(pkt_in[PKT_W*sel_q +: PKT_W]);
  assign busy     = (state_q != A_IDLE);

  switch_out_arbiter_rr_pick u_rr_pick (
    .req    (r),
    .ptr    (rr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // FSM, selection and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= A_IDLE;
      rr_q     <= 2'd0;
      sel_q    <= 2'd0;
      sel_oh_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      sel_oh_q <= sel_oh_d;
    end
  end

  // Next state, grant and load; a withdrawn request in GRANT leaves rr_ptr alone.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    sel_oh_d = sel_oh_q;
    grant    = '0;
    load     = 1'b0;
    case (state_q)
      A_IDLE: begin
        if (pick_any && out_free) begin
          state_d  = A_GRANT;
          sel_d    = pick_idx;
          sel_oh_d = pick_onehot;
        end
      end
      A_GRANT: begin
        state_d = A_IDLE;
        grant   = r & sel_oh_q;
        if (|(r & sel_oh_q)) begin
          load = 1'b1;
          rr_d = rr_next(sel_q);
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  // Output register: a load in the same cycle as a drain keeps valid_out set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
    end else if (load) begin
      valid_out  <= 1'b1;
      source_out <= head.source;
      target_out <= head.target;
      data_out   <= head.data;
    end else if (out_ready) begin
      valid_out  <= 1'b0;
    end
  end

  // Delivered-packet counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (valid_out && out_ready && (pkt_cnt != {CNT_W{1'b1}})) begin
      pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed bench for switch_out_arbiter instantiated as egress port 2.
module tb_switch_out_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  dst [4];
  logic [15:0] pk [4];
  logic [15:0] req_dst;
  logic [63:0] pkt_in;
  logic [3:0]  grant;
  logic        out_ready;
  logic        valid_out;
  logic [3:0]  source_out;
  logic [3:0]  target_out;
  logic [7:0]  data_out;
  logic        busy;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int errors = 0;

  assign req_dst = {dst[3], dst[2], dst[1], dst[0]};
  assign pkt_in  = {pk[3], pk[2], pk[1], pk[0]};

  always #5 clk = ~clk;

  switch_out_arbiter #(.OUT_ID(2), .NPORTS(4), .PKT_W(16), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_dst    (req_dst),
    .pkt_in     (pkt_in),
    .grant      (grant),
    .out_ready  (out_ready),
    .valid_out  (valid_out),
    .source_out (source_out),
    .target_out (target_out),
    .data_out   (data_out),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_dst();
    for (int i = 0; i < 4; i++) dst[i] = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) dst[i] = 4'b0100;
    pk[0] = 16'h5C30; pk[1] = 16'h5C31; pk[2] = 16'h5C32; pk[3] = 16'h5C33;
    repeat (3) @(posedge clk);
    smp();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", grant); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_out); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", pkt_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({data_out, target_out, source_out} !== 16'h0000) begin errors++; $display("FAIL rst_outs got %h exp 0000", {data_out, target_out, source_out}); end
    rst_n = 1'b1;
    smp();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b exp 0001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_first_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_mid_grant got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    req_valid = 4'h0;
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", valid_out); end
    smp();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    step();
    clear_dst();
    dst[1] = 4'b0100;
    pk[0] = 16'hFFFF; pk[1] = 16'hA512; pk[2] = 16'h0000; pk[3] = 16'h1234;
    req_valid = 4'b0010;
    smp();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_idle_grant got %b exp 0000", grant); end
    step(); smp();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", grant); end
    step();
    req_valid = 4'b0000;
    smp();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid_out); end
    checks++; if ({data_out, target_out, source_out} !== 16'hA512) begin errors++; $display("FAIL single_pkt got %h exp a512", {data_out, target_out, source_out}); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_post_grant got %b exp 0000", grant); end
    step(); smp();
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", pkt_cnt); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", valid_out); end
  endtask

  task automatic test_filter();
    step();
    clear_dst();
    dst[0] = 4'b0100;
    dst[3] = 4'b0001;
    req_valid = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      step(); smp();
      checks++; if ({grant, busy} !== 5'b00000) begin errors++; $display("FAIL filter_%0d got grant %b busy %b exp 0000 0", k, grant, busy); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dst[i] = 4'b0100;
      pk[i]  = 16'hD020 + 16'(i * 256) + 16'(i);
    end
    out_ready = 1'b1;
    req_valid = 4'hF;
    smp();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_idle_grant got %b exp 0000", grant); end
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step(); smp();
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", k, grant, exp_g); end
      step();
      if (k == 4) req_valid = 4'b0000;
      smp();
      checks++; if ({grant, valid_out, source_out} !== {4'b0000, 1'b1, 4'(k % 4)}) begin errors++; $display("FAIL rr_out_%0d got grant %b valid %b src %0d exp 0000 1 %0d", k, grant, valid_out, source_out, k % 4); end
    end
    step(); smp();
    checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("FAIL rr_cnt got %0d exp 5", pkt_cnt); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", valid_out); end
  endtask

  task automatic test_backpressure();
    step();
    clear_dst();
    dst[0] = 4'b0100;
    pk[0] = 16'h7E41;
    out_ready = 1'b0;
    req_valid = 4'b0001;
    smp();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_idle_grant got %b exp 0000", grant); end
    step(); smp();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bp_first_grant got %b exp 0001", grant); end
    step();
    pk[0] = 16'h9B41;
    for (int k = 0; k < 4; k++) begin
      smp();
      checks++; if ({grant, valid_out, data_out, target_out, source_out} !== {4'b0000, 1'b1, 16'h7E41}) begin errors++; $display("FAIL bp_hold_%0d got grant %b valid %b pkt %h exp 0000 1 7e41", k, grant, valid_out, {data_out, target_out, source_out}); end
      checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("FAIL bp_hold_cnt_%0d got %0d exp 5", k, pkt_cnt); end
      step();
    end
    out_ready = 1'b1;
    smp();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_release_grant got %b exp 0000", grant); end
    step(); smp();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bp_regrant got %b exp 0001", grant); end
    checks++; if (pkt_cnt !== 16'd6) begin errors++; $display("FAIL bp_cnt6 got %0d exp 6", pkt_cnt); end
    step();
    req_valid = 4'b0000;
    smp();
    checks++; if ({valid_out, data_out, source_out} !== {1'b1, 8'h9B, 4'h1}) begin errors++; $display("FAIL bp_second_pkt got valid %b data %h src %h exp 1 9b 1", valid_out, data_out, source_out); end
    step(); smp();
    checks++; if (pkt_cnt !== 16'd7) begin errors++; $display("FAIL bp_cnt7 got %0d exp 7", pkt_cnt); end
  endtask

  task automatic test_withdraw();
    step();
    clear_dst();
    dst[0] = 4'b0100;
    dst[1] = 4'b0100;
    pk[0] = 16'h6650;
    pk[1] = 16'h4431;
    req_valid = 4'b0010;
    smp();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_idle_grant got %b exp 0000", grant); end
    step(); smp();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wd_grant got %b exp 0010", grant); end
    req_valid = 4'b0000;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_dropped_grant got %b exp 0000", grant); end
    step();
    req_valid = 4'b0011;
    smp();
    checks++; if ({grant, valid_out, busy} !== 6'b000000) begin errors++; $display("FAIL wd_after got grant %b valid %b busy %b exp 0000 0 0", grant, valid_out, busy); end
    step(); smp();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wd_rr_kept got %b exp 0010", grant); end
    step();
    req_valid = 4'b0000;
    smp();
    checks++; if ({valid_out, data_out, target_out, source_out} !== {1'b1, 16'h4431}) begin errors++; $display("FAIL wd_pkt got valid %b pkt %h exp 1 4431", valid_out, {data_out, target_out, source_out}); end
    step(); smp();
    checks++; if (pkt_cnt !== 16'd8) begin errors++; $display("FAIL wd_cnt got %0d exp 8", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
